// File: rtl/draw_sprite_array_pkg.sv
// Shared VGA constants and the timing-bus type used by the sprite array pipeline.
package draw_sprite_array_pkg;

  localparam int unsigned TIMING_W = 11;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned POS_W    = 12;
  // Window compares run one bit wider than positions so x+SPR_W-1 never wraps.
  localparam int unsigned CMP_W    = 13;

  typedef struct packed {
    logic [TIMING_W-1:0] hcount;
    logic [TIMING_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } timing_t;

endpackage

// File: rtl/draw_sprite_array_sprite_hit.sv
// Window comparator for one sprite channel: asserts when the current pixel lies inside
// the sprite rectangle and the channel is enabled outside blanking.
module sprite_hit
  import draw_sprite_array_pkg::*;
#(
  parameter int unsigned SPR_W = 32,
  parameter int unsigned SPR_H = 32
) (
  input  logic                i_en,
  input  logic                i_blank,
  input  logic [TIMING_W-1:0] i_hcount,
  input  logic [TIMING_W-1:0] i_vcount,
  input  logic [POS_W-1:0]    i_xpos,
  input  logic [POS_W-1:0]    i_ypos,
  output logic                o_hit
);

  logic [CMP_W-1:0] w_h;
  logic [CMP_W-1:0] w_v;
  logic [CMP_W-1:0] w_x;
  logic [CMP_W-1:0] w_y;
  logic [CMP_W-1:0] w_x_end;
  logic [CMP_W-1:0] w_y_end;
  logic             w_in_x;
  logic             w_in_y;

  assign w_h     = CMP_W'(i_hcount);
  assign w_v     = CMP_W'(i_vcount);
  assign w_x     = CMP_W'(i_xpos);
  assign w_y     = CMP_W'(i_ypos);
  assign w_x_end = w_x + CMP_W'(SPR_W - 1);
  assign w_y_end = w_y + CMP_W'(SPR_H - 1);

  assign w_in_x = (w_h >= w_x) && (w_h <= w_x_end);
  assign w_in_y = (w_v >= w_y) && (w_v <= w_y_end);
  assign o_hit  = i_en && !i_blank && w_in_x && w_in_y;

endmodule

// File: rtl/draw_sprite_array.sv
// Multi-channel sprite overlay: three-stage pipeline (select/address, ROM align, mix)
// with vblank-latched channel shadows and a per-frame sprite collision flag.
module draw_sprite_array
  import draw_sprite_array_pkg::*;
#(
  parameter int unsigned     N_SPR  = 4,
  parameter int unsigned     SPR_W  = 32,
  parameter int unsigned     SPR_H  = 32,
  parameter logic [RGB_W-1:0] TRANSP = 12'h0F0,
  parameter int unsigned     ADDR_W = $clog2(SPR_W * SPR_H)
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [TIMING_W-1:0]      hcount_in,
  input  logic [TIMING_W-1:0]      vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [RGB_W-1:0]         rgb_in,
  input  logic [POS_W*N_SPR-1:0]   xpos_in,
  input  logic [POS_W*N_SPR-1:0]   ypos_in,
  input  logic [N_SPR-1:0]         en_in,
  input  logic [RGB_W-1:0]         rgb_pixel,
  output logic [TIMING_W-1:0]      hcount_out,
  output logic [TIMING_W-1:0]      vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [RGB_W-1:0]         rgb_out,
  output logic [ADDR_W-1:0]        pixel_addr,
  output logic                     collision_out
);

  localparam int unsigned SEL_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  logic                   r_vblnk_prev;
  logic                   w_vblnk_rise;
  logic [POS_W*N_SPR-1:0] r_xpos_sh;
  logic [POS_W*N_SPR-1:0] r_ypos_sh;
  logic [N_SPR-1:0]       r_en_sh;

  logic [N_SPR-1:0]       w_hit;
  logic [SEL_W-1:0]       w_sel;
  logic                   w_sel_valid;
  logic                   w_multi;
  logic [POS_W-1:0]       w_x_sel;
  logic [POS_W-1:0]       w_y_sel;
  logic [CMP_W-1:0]       w_dx;
  logic [CMP_W-1:0]       w_dy;
  logic [ADDR_W-1:0]      w_addr;
  timing_t                w_timing_in;

  timing_t                r_s1_timing;
  logic [RGB_W-1:0]       r_s1_rgb;
  logic                   r_s1_sel_valid;
  logic                   r_s1_multi;
  logic [ADDR_W-1:0]      r_pixel_addr;

  timing_t                r_s2_timing;
  logic [RGB_W-1:0]       r_s2_rgb;
  logic                   r_s2_sel_valid;
  logic                   r_s2_multi;

  timing_t                r_timing_out;
  logic [RGB_W-1:0]       r_rgb_out;
  logic [RGB_W-1:0]       w_rgb_mix;
  logic                   w_opaque;
  logic                   w_coll_hit;
  logic                   r_coll_acc;
  logic                   r_collision;

  assign w_vblnk_rise = vblnk_in && !r_vblnk_prev;
  assign w_timing_in  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  // Shadows only change at the vblank edge so a frame is always drawn from one channel set.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_xpos_sh    <= '0;
      r_ypos_sh    <= '0;
      r_en_sh      <= '0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vblnk_rise) begin
        r_xpos_sh <= xpos_in;
        r_ypos_sh <= ypos_in;
        r_en_sh   <= en_in;
      end
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
    ) u_sprite_hit (
      .i_en     (r_en_sh[g]),
      .i_blank  (hblnk_in || vblnk_in),
      .i_hcount (hcount_in),
      .i_vcount (vcount_in),
      .i_xpos   (r_xpos_sh[POS_W*g +: POS_W]),
      .i_ypos   (r_ypos_sh[POS_W*g +: POS_W]),
      .o_hit    (w_hit[g])
    );
  end

  // Descending scan so the lowest-index hitting channel wins.
  always_comb begin
    w_sel       = '0;
    w_sel_valid = 1'b0;
    w_multi     = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        if (w_sel_valid) w_multi = 1'b1;
        w_sel_valid = 1'b1;
        w_sel       = SEL_W'(i);
      end
    end
  end

  assign w_x_sel = r_xpos_sh[POS_W*w_sel +: POS_W];
  assign w_y_sel = r_ypos_sh[POS_W*w_sel +: POS_W];
  assign w_dx    = CMP_W'(hcount_in) - CMP_W'(w_x_sel);
  assign w_dy    = CMP_W'(vcount_in) - CMP_W'(w_y_sel);
  assign w_addr  = w_sel_valid ? ADDR_W'(w_dy * CMP_W'(SPR_W) + w_dx) : '0;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_s1_timing    <= '0;
      r_s1_rgb       <= '0;
      r_s1_sel_valid <= 1'b0;
      r_s1_multi     <= 1'b0;
      r_pixel_addr   <= '0;
      r_s2_timing    <= '0;
      r_s2_rgb       <= '0;
      r_s2_sel_valid <= 1'b0;
      r_s2_multi     <= 1'b0;
    end else begin
      r_s1_timing    <= w_timing_in;
      r_s1_rgb       <= rgb_in;
      r_s1_sel_valid <= w_sel_valid;
      r_s1_multi     <= w_multi;
      r_pixel_addr   <= w_addr;
      r_s2_timing    <= r_s1_timing;
      r_s2_rgb       <= r_s1_rgb;
      r_s2_sel_valid <= r_s1_sel_valid;
      r_s2_multi     <= r_s1_multi;
    end
  end

  always_comb begin
    w_opaque   = (rgb_pixel != TRANSP);
    w_coll_hit = r_s2_multi && w_opaque;
    w_rgb_mix  = r_s2_rgb;
    if (r_s2_timing.hblnk || r_s2_timing.vblnk) begin
      w_rgb_mix = '0;
    end else if (r_s2_sel_valid && w_opaque) begin
      w_rgb_mix = rgb_pixel;
    end
  end

  // A hit landing on the vblank edge itself seeds the next frame's accumulator.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_timing_out <= '0;
      r_rgb_out    <= '0;
      r_coll_acc   <= 1'b0;
      r_collision  <= 1'b0;
    end else begin
      r_timing_out <= r_s2_timing;
      r_rgb_out    <= w_rgb_mix;
      if (w_vblnk_rise) begin
        r_collision <= r_coll_acc;
        r_coll_acc  <= w_coll_hit;
      end else begin
        r_coll_acc  <= r_coll_acc || w_coll_hit;
      end
    end
  end

  assign hcount_out    = r_timing_out.hcount;
  assign vcount_out    = r_timing_out.vcount;
  assign hsync_out     = r_timing_out.hsync;
  assign vsync_out     = r_timing_out.vsync;
  assign hblnk_out     = r_timing_out.hblnk;
  assign vblnk_out     = r_timing_out.vblnk;
  assign rgb_out       = r_rgb_out;
  assign pixel_addr    = r_pixel_addr;
  assign collision_out = r_collision;

endmodule

// File: tb/tb_draw_sprite_array.sv
// Directed bench for draw_sprite_array with a synchronous address-pattern ROM model.
module tb_draw_sprite_array;

  localparam int N_SPR = 4;

  logic                 pclk = 1'b0;
  logic                 rst;
  logic [10:0]          hcount_in, vcount_in;
  logic                 hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]          rgb_in;
  logic [12*N_SPR-1:0]  xpos_in, ypos_in;
  logic [N_SPR-1:0]     en_in;
  logic [11:0]          rgb_pixel;
  logic [10:0]          hcount_out, vcount_out;
  logic                 hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]          rgb_out;
  logic [9:0]           pixel_addr;
  logic                 collision_out;
  logic                 rom_transp;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  // ROM[a] = {2'b10, a}: never equals the transparent key unless forced.
  always @(posedge pclk) rgb_pixel <= rom_transp ? 12'h0F0 : {2'b10, pixel_addr};

  draw_sprite_array #(
    .N_SPR (N_SPR)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .hblnk_in      (hblnk_in),
    .vblnk_in      (vblnk_in),
    .rgb_in        (rgb_in),
    .xpos_in       (xpos_in),
    .ypos_in       (ypos_in),
    .en_in         (en_in),
    .rgb_pixel     (rgb_pixel),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .hblnk_out     (hblnk_out),
    .vblnk_out     (vblnk_out),
    .rgb_out       (rgb_out),
    .pixel_addr    (pixel_addr),
    .collision_out (collision_out)
  );

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [11:0] x, input logic [11:0] y);
    xpos_in[12*ch +: 12] = x;
    ypos_in[12*ch +: 12] = y;
  endtask

  task automatic hold_pixel(input logic [10:0] h, input logic [10:0] v,
                            input logic [11:0] rgb, input logic hb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    repeat (3) step();
  endtask

  // Drain the pipeline under hblank, then raise vblank.
  task automatic vblank_edge();
    hblnk_in = 1'b1;
    vblnk_in = 1'b0;
    repeat (3) step();
    vblnk_in = 1'b1;
    repeat (3) step();
    vblnk_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hFFF;
    xpos_in = '0; ypos_in = '0; en_in = '1;
    repeat (2) step();
    checks++;
    if (hcount_out !== 11'd0) begin
      errors++; $display("FAIL reset_hcount: got %0d want 0", hcount_out);
    end
    checks++;
    if (hsync_out !== 1'b0) begin
      errors++; $display("FAIL reset_hsync: got %b want 0", hsync_out);
    end
    checks++;
    if (rgb_out !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h want 000", rgb_out);
    end
    checks++;
    if (pixel_addr !== 10'd0) begin
      errors++; $display("FAIL reset_addr: got %0d want 0", pixel_addr);
    end
    checks++;
    if (collision_out !== 1'b0) begin
      errors++; $display("FAIL reset_coll: got %b want 0", collision_out);
    end
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    set_ch(0, 12'd100, 12'd50);
    en_in = 4'b0001;
    hold_pixel(11'd100, 11'd50, 12'h123, 1'b0);
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++; $display("FAIL reset_no_draw: got %h want 123", rgb_out);
    end
  endtask

  task automatic test_single();
    vblank_edge();
    hold_pixel(11'd100, 11'd50, 12'h123, 1'b0);
    checks++;
    if (pixel_addr !== 10'd0) begin
      errors++; $display("FAIL single_addr0: got %0d want 0", pixel_addr);
    end
    checks++;
    if (rgb_out !== 12'h800) begin
      errors++; $display("FAIL single_rgb0: got %h want 800", rgb_out);
    end
    hold_pixel(11'd131, 11'd81, 12'h123, 1'b0);
    checks++;
    if (pixel_addr !== 10'd1023) begin
      errors++; $display("FAIL single_addr1023: got %0d want 1023", pixel_addr);
    end
    checks++;
    if (rgb_out !== 12'hBFF) begin
      errors++; $display("FAIL single_rgb1023: got %h want bff", rgb_out);
    end
    hold_pixel(11'd132, 11'd50, 12'h123, 1'b0);
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++; $display("FAIL single_right_edge: got %h want 123", rgb_out);
    end
    hold_pixel(11'd100, 11'd49, 12'h777, 1'b0);
    checks++;
    if (rgb_out !== 12'h777) begin
      errors++; $display("FAIL single_top_edge: got %h want 777", rgb_out);
    end
  endtask

  task automatic test_latency();
    hcount_in = 11'd500; hsync_in = 1'b1; rgb_in = 12'h0AA;
    step();
    hcount_in = 11'd501; hsync_in = 1'b0;
    step();
    checks++;
    if (hcount_out !== 11'd100) begin
      errors++; $display("FAIL latency_early: got %0d want 100", hcount_out);
    end
    step();
    checks++;
    if (hcount_out !== 11'd500 || hsync_out !== 1'b1) begin
      errors++;
      $display("FAIL latency_3: got h=%0d hs=%b want h=500 hs=1", hcount_out, hsync_out);
    end
    checks++;
    if (rgb_out !== 12'h0AA) begin
      errors++; $display("FAIL latency_rgb: got %h want 0aa", rgb_out);
    end
    step();
    checks++;
    if (hcount_out !== 11'd501 || hsync_out !== 1'b0) begin
      errors++;
      $display("FAIL latency_4: got h=%0d hs=%b want h=501 hs=0", hcount_out, hsync_out);
    end
  endtask

  task automatic test_priority();
    set_ch(0, 12'd200, 12'd200);
    set_ch(2, 12'd202, 12'd200);
    en_in = 4'b0101;
    vblank_edge();
    hold_pixel(11'd205, 11'd203, 12'h111, 1'b0);
    checks++;
    if (pixel_addr !== 10'd101 || rgb_out !== 12'h865) begin
      errors++;
      $display("FAIL prio_ch0: got addr=%0d rgb=%h want addr=101 rgb=865", pixel_addr, rgb_out);
    end
    checks++;
    if (collision_out !== 1'b0) begin
      errors++; $display("FAIL prio_coll_hold: got %b want 0", collision_out);
    end
    en_in = 4'b0100;
    vblank_edge();
    checks++;
    if (collision_out !== 1'b1) begin
      errors++; $display("FAIL prio_coll_set: got %b want 1", collision_out);
    end
    hold_pixel(11'd205, 11'd203, 12'h111, 1'b0);
    checks++;
    if (pixel_addr !== 10'd99 || rgb_out !== 12'h863) begin
      errors++;
      $display("FAIL prio_ch2: got addr=%0d rgb=%h want addr=99 rgb=863", pixel_addr, rgb_out);
    end
    checks++;
    if (collision_out !== 1'b1) begin
      errors++; $display("FAIL prio_coll_frame: got %b want 1", collision_out);
    end
    vblank_edge();
    checks++;
    if (collision_out !== 1'b0) begin
      errors++; $display("FAIL prio_coll_clear: got %b want 0", collision_out);
    end
  endtask

  task automatic test_transparent();
    set_ch(0, 12'd100, 12'd50);
    set_ch(1, 12'd100, 12'd50);
    en_in = 4'b0011;
    vblank_edge();
    rom_transp = 1'b1;
    hold_pixel(11'd110, 11'd60, 12'hABC, 1'b0);
    checks++;
    if (rgb_out !== 12'hABC) begin
      errors++; $display("FAIL transp_pass: got %h want abc", rgb_out);
    end
    vblank_edge();
    rom_transp = 1'b0;
    checks++;
    if (collision_out !== 1'b0) begin
      errors++; $display("FAIL transp_no_coll: got %b want 0", collision_out);
    end
  endtask

  task automatic test_tear();
    set_ch(0, 12'd100, 12'd290);
    set_ch(1, 12'd0, 12'd0);
    en_in = 4'b0001;
    vblank_edge();
    hold_pixel(11'd100, 11'd300, 12'h222, 1'b0);
    checks++;
    if (rgb_out !== 12'h940) begin
      errors++; $display("FAIL tear_before: got %h want 940", rgb_out);
    end
    set_ch(0, 12'd400, 12'd290);
    hold_pixel(11'd100, 11'd300, 12'h222, 1'b0);
    checks++;
    if (rgb_out !== 12'h940) begin
      errors++; $display("FAIL tear_old_pos: got %h want 940", rgb_out);
    end
    hold_pixel(11'd400, 11'd300, 12'h222, 1'b0);
    checks++;
    if (rgb_out !== 12'h222) begin
      errors++; $display("FAIL tear_new_pos_early: got %h want 222", rgb_out);
    end
    vblank_edge();
    hold_pixel(11'd400, 11'd300, 12'h222, 1'b0);
    checks++;
    if (rgb_out !== 12'h940) begin
      errors++; $display("FAIL tear_new_pos: got %h want 940", rgb_out);
    end
    hold_pixel(11'd100, 11'd300, 12'h222, 1'b0);
    checks++;
    if (rgb_out !== 12'h222) begin
      errors++; $display("FAIL tear_old_gone: got %h want 222", rgb_out);
    end
  endtask

  task automatic test_clip();
    set_ch(0, 12'd1270, 12'd0);
    set_ch(1, 12'd4090, 12'd0);
    en_in = 4'b0011;
    vblank_edge();
    hold_pixel(11'd0, 11'd0, 12'h456, 1'b0);
    checks++;
    if (rgb_out !== 12'h456 || pixel_addr !== 10'd0) begin
      errors++;
      $display("FAIL clip_h0: got rgb=%h addr=%0d want rgb=456 addr=0", rgb_out, pixel_addr);
    end
    hold_pixel(11'd20, 11'd0, 12'h456, 1'b0);
    checks++;
    if (rgb_out !== 12'h456) begin
      errors++; $display("FAIL clip_h20: got %h want 456", rgb_out);
    end
    hold_pixel(11'd1275, 11'd0, 12'h456, 1'b0);
    checks++;
    if (pixel_addr !== 10'd5 || rgb_out !== 12'h805) begin
      errors++;
      $display("FAIL clip_visible: got addr=%0d rgb=%h want addr=5 rgb=805", pixel_addr, rgb_out);
    end
    hold_pixel(11'd1275, 11'd0, 12'h456, 1'b1);
    checks++;
    if (rgb_out !== 12'h000 || hblnk_out !== 1'b1) begin
      errors++;
      $display("FAIL clip_hblnk: got rgb=%h hb=%b want rgb=000 hb=1", rgb_out, hblnk_out);
    end
  endtask

  task automatic test_reset_mid();
    set_ch(0, 12'd100, 12'd390);
    set_ch(1, 12'd100, 12'd390);
    en_in = 4'b0011;
    vblank_edge();
    hold_pixel(11'd100, 11'd400, 12'h321, 1'b0);
    checks++;
    if (rgb_out !== 12'h940) begin
      errors++; $display("FAIL rmid_draw: got %h want 940", rgb_out);
    end
    vblank_edge();
    checks++;
    if (collision_out !== 1'b1) begin
      errors++; $display("FAIL rmid_coll_pre: got %b want 1", collision_out);
    end
    hold_pixel(11'd100, 11'd400, 12'h321, 1'b0);
    rst = 1'b1;
    step();
    checks++;
    if (rgb_out !== 12'h000 || vcount_out !== 11'd0 || hcount_out !== 11'd0) begin
      errors++;
      $display("FAIL rmid_out: got rgb=%h v=%0d h=%0d want 000/0/0", rgb_out, vcount_out,
               hcount_out);
    end
    checks++;
    if (collision_out !== 1'b0 || pixel_addr !== 10'd0) begin
      errors++;
      $display("FAIL rmid_coll_addr: got coll=%b addr=%0d want 0/0", collision_out, pixel_addr);
    end
    rst = 1'b0;
    hold_pixel(11'd100, 11'd400, 12'h321, 1'b0);
    checks++;
    if (rgb_out !== 12'h321 || vcount_out !== 11'd400) begin
      errors++;
      $display("FAIL rmid_no_draw: got rgb=%h v=%0d want 321/400", rgb_out, vcount_out);
    end
    vblank_edge();
    hold_pixel(11'd100, 11'd400, 12'h321, 1'b0);
    checks++;
    if (rgb_out !== 12'h940) begin
      errors++; $display("FAIL rmid_redraw: got %h want 940", rgb_out);
    end
  endtask

  initial begin
    rom_transp = 1'b0;
    test_reset();
    test_single();
    test_latency();
    test_priority();
    test_transparent();
    test_tear();
    test_clip();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
